// File: rtl/dmem_m2_stage.sv
// Data-memory M2 stage with the M2/W pipeline register.
// The word read for the M1 instruction is registered at the M1->M2 edge. A store
// that commits at that same edge to the same word is merged back into the read
// data through a byte-mask bypass. Loads are extracted and extended in M2.
module dmem_m2_stage #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] alu_result_m1,
  input  logic        reg_write_m2,
  input  logic [1:0]  result_src_m2,
  input  logic        mem_write_m2,
  input  logic [2:0]  funct3_m2,
  input  logic [31:0] alu_result_m2,
  input  logic [31:0] write_data_m2,
  input  logic [4:0]  rd_m2,
  input  logic [31:0] pc_plus4_m2,
  output logic        reg_write_w,
  output logic [1:0]  result_src_w,
  output logic [31:0] alu_result_w,
  output logic [31:0] read_data_w,
  output logic [4:0]  rd_w,
  output logic [31:0] pc_plus4_w,
  output logic        misaligned_w
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]           ram [DEPTH];

  logic                  first_q;
  logic                  adv;
  logic [DEPTH_LOG2-1:0] idx_m1;
  logic [DEPTH_LOG2-1:0] idx_m2;
  logic [1:0]            offset;
  logic                  is_load;
  logic                  misaligned;
  logic [3:0]            byte_en;
  logic [31:0]           lane_data;
  logic                  commit;

  logic [31:0]           rdata_q;
  logic [3:0]            byp_mask_q;
  logic [31:0]           byp_data_q;
  logic [31:0]           merged;
  logic [31:0]           shifted;
  logic [31:0]           ext_data;

  logic                  unused_addr_bits;

  assign idx_m1  = alu_result_m1[DEPTH_LOG2+1:2];
  assign idx_m2  = alu_result_m2[DEPTH_LOG2+1:2];
  assign offset  = alu_result_m2[1:0];
  assign is_load = (result_src_m2 == 2'b01);

  assign unused_addr_bits = ^{alu_result_m1[31:DEPTH_LOG2+2], alu_result_m1[1:0]};

  // The first edge after reset release always advances, regardless of stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q <= 1'b1;
    end else begin
      first_q <= 1'b0;
    end
  end

  assign adv = ~stall | first_q;

  // Alignment fault for halfword/word loads and stores.
  always_comb begin
    misaligned = 1'b0;
    if (is_load || mem_write_m2) begin
      if (funct3_m2[1:0] == 2'b01) begin
        misaligned = offset[0];
      end else if (funct3_m2[1:0] == 2'b10) begin
        misaligned = (offset != 2'b00);
      end
    end
  end

  // Store byte enables and lane-replicated store data.
  always_comb begin
    byte_en   = '0;
    lane_data = write_data_m2;
    case (funct3_m2)
      3'b000: begin
        byte_en   = 4'b0001 << offset;
        lane_data = {4{write_data_m2[7:0]}};
      end
      3'b001: begin
        byte_en   = offset[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{write_data_m2[15:0]}};
      end
      3'b010: begin
        byte_en   = 4'b1111;
        lane_data = write_data_m2;
      end
      default: begin
        byte_en   = '0;
        lane_data = write_data_m2;
      end
    endcase
  end

  assign commit = mem_write_m2 & adv & ~misaligned & (byte_en != '0);

  // Byte-masked RAM write; rst blocks a store that is in flight.
  always_ff @(posedge clk) begin
    if (commit && !rst) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          ram[idx_m2][8*b +: 8] <= lane_data[8*b +: 8];
        end
      end
    end
  end

  // Early read for the M1 instruction plus capture of a same-edge store to that word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q    <= '0;
      byp_mask_q <= '0;
      byp_data_q <= '0;
    end else if (adv) begin
      rdata_q    <= ram[idx_m1];
      byp_mask_q <= (commit && (idx_m2 == idx_m1)) ? byte_en : 4'b0000;
      byp_data_q <= lane_data;
    end
  end

  // Merge bypassed store bytes over the stale RAM read.
  always_comb begin
    merged = rdata_q;
    for (int unsigned b = 0; b < 4; b++) begin
      if (byp_mask_q[b]) begin
        merged[8*b +: 8] = byp_data_q[8*b +: 8];
      end
    end
  end

  assign shifted = merged >> {offset, 3'b000};

  // Load size selection and sign/zero extension.
  always_comb begin
    ext_data = '0;
    case (funct3_m2)
      3'b000:  ext_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ext_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  ext_data = shifted;
      3'b100:  ext_data = {24'h000000, shifted[7:0]};
      3'b101:  ext_data = {16'h0000, shifted[15:0]};
      default: ext_data = '0;
    endcase
  end

  // M2/W pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_w  <= 1'b0;
      result_src_w <= '0;
      alu_result_w <= '0;
      read_data_w  <= '0;
      rd_w         <= '0;
      pc_plus4_w   <= '0;
      misaligned_w <= 1'b0;
    end else if (adv) begin
      reg_write_w  <= reg_write_m2 & ~misaligned;
      result_src_w <= result_src_m2;
      alu_result_w <= alu_result_m2;
      read_data_w  <= ext_data;
      rd_w         <= rd_m2;
      pc_plus4_w   <= pc_plus4_m2;
      misaligned_w <= misaligned;
    end
  end

endmodule

// File: tb/tb_dmem_m2_stage.sv
// Directed bench for dmem_m2_stage: stores, loads, bypass, alignment, stall and reset.
module tb_dmem_m2_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [31:0] alu_result_m1;
  logic        reg_write_m2;
  logic [1:0]  result_src_m2;
  logic        mem_write_m2;
  logic [2:0]  funct3_m2;
  logic [31:0] alu_result_m2;
  logic [31:0] write_data_m2;
  logic [4:0]  rd_m2;
  logic [31:0] pc_plus4_m2;
  logic        reg_write_w;
  logic [1:0]  result_src_w;
  logic [31:0] alu_result_w;
  logic [31:0] read_data_w;
  logic [4:0]  rd_w;
  logic [31:0] pc_plus4_w;
  logic        misaligned_w;

  int tests_run = 0;
  int tests_failed = 0;

  dmem_m2_stage #(.DEPTH_LOG2(10)) dut (
    .clk(clk), .rst(rst), .stall(stall), .alu_result_m1(alu_result_m1),
    .reg_write_m2(reg_write_m2), .result_src_m2(result_src_m2),
    .mem_write_m2(mem_write_m2), .funct3_m2(funct3_m2),
    .alu_result_m2(alu_result_m2), .write_data_m2(write_data_m2),
    .rd_m2(rd_m2), .pc_plus4_m2(pc_plus4_m2),
    .reg_write_w(reg_write_w), .result_src_w(result_src_w),
    .alu_result_w(alu_result_w), .read_data_w(read_data_w),
    .rd_w(rd_w), .pc_plus4_w(pc_plus4_w), .misaligned_w(misaligned_w)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic m2_nop;
    reg_write_m2  = 1'b0;
    result_src_m2 = 2'b00;
    mem_write_m2  = 1'b0;
    funct3_m2     = 3'b000;
    alu_result_m2 = 32'h0;
    write_data_m2 = 32'h0;
    rd_m2         = 5'd0;
    pc_plus4_m2   = 32'h0;
  endtask

  task automatic m2_load(input logic [31:0] a, input logic [2:0] f3, input logic [4:0] rd);
    reg_write_m2  = 1'b1;
    result_src_m2 = 2'b01;
    mem_write_m2  = 1'b0;
    funct3_m2     = f3;
    alu_result_m2 = a;
    write_data_m2 = 32'h0;
    rd_m2         = rd;
    pc_plus4_m2   = a + 32'd4;
  endtask

  task automatic m2_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    reg_write_m2  = 1'b0;
    result_src_m2 = 2'b00;
    mem_write_m2  = 1'b1;
    funct3_m2     = f3;
    alu_result_m2 = a;
    write_data_m2 = d;
    rd_m2         = 5'd0;
    pc_plus4_m2   = a + 32'd4;
  endtask

  // Load passes through M1 (address) then M2; W holds it after the second edge.
  task automatic do_load(input logic [31:0] a, input logic [2:0] f3, input logic [4:0] rd);
    m2_nop();
    alu_result_m1 = a;
    step();
    m2_load(a, f3, rd);
    alu_result_m1 = 32'h0;
    step();
    m2_nop();
  endtask

  task automatic do_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    m2_store(a, f3, d);
    alu_result_m1 = 32'h0;
    step();
    m2_nop();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    stall = 1'b0;
    alu_result_m1 = 32'h0;
    m2_nop();
    step();
    tests_run++; if (reg_write_w !== 1'b0) begin tests_failed++; $display("FAIL rst_reg_write: got %b expected 0", reg_write_w); end
    tests_run++; if (result_src_w !== 2'b00) begin tests_failed++; $display("FAIL rst_result_src: got %b expected 00", result_src_w); end
    tests_run++; if (alu_result_w !== 32'h0) begin tests_failed++; $display("FAIL rst_alu_result: got %h expected 0", alu_result_w); end
    tests_run++; if (read_data_w !== 32'h0) begin tests_failed++; $display("FAIL rst_read_data: got %h expected 0", read_data_w); end
    tests_run++; if (rd_w !== 5'd0) begin tests_failed++; $display("FAIL rst_rd: got %0d expected 0", rd_w); end
    tests_run++; if (pc_plus4_w !== 32'h0) begin tests_failed++; $display("FAIL rst_pc_plus4: got %h expected 0", pc_plus4_w); end
    tests_run++; if (misaligned_w !== 1'b0) begin tests_failed++; $display("FAIL rst_misaligned: got %b expected 0", misaligned_w); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_store_load;
    do_store(32'h100, 3'b010, 32'hDEADBEEF);
    do_load(32'h100, 3'b010, 5'd5);
    tests_run++; if (read_data_w !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL lw_data: got %h expected deadbeef", read_data_w); end
    tests_run++; if (reg_write_w !== 1'b1) begin tests_failed++; $display("FAIL lw_reg_write: got %b expected 1", reg_write_w); end
    tests_run++; if (rd_w !== 5'd5) begin tests_failed++; $display("FAIL lw_rd: got %0d expected 5", rd_w); end
    tests_run++; if (result_src_w !== 2'b01) begin tests_failed++; $display("FAIL lw_result_src: got %b expected 01", result_src_w); end
    tests_run++; if (alu_result_w !== 32'h100) begin tests_failed++; $display("FAIL lw_alu_result: got %h expected 100", alu_result_w); end
    tests_run++; if (pc_plus4_w !== 32'h104) begin tests_failed++; $display("FAIL lw_pc_plus4: got %h expected 104", pc_plus4_w); end
    tests_run++; if (misaligned_w !== 1'b0) begin tests_failed++; $display("FAIL lw_misaligned: got %b expected 0", misaligned_w); end
  endtask

  task automatic test_load_extract;
    logic [31:0] addr_v [7] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h101, 32'h100};
    logic [2:0]  f3_v   [7] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000, 3'b100, 3'b011};
    logic [31:0] exp_v  [7] = '{32'hFFFFFFDE, 32'h000000DE, 32'h0000DEAD, 32'hFFFFDEAD,
                                32'hFFFFFFEF, 32'h000000BE, 32'h00000000};
    for (int i = 0; i < 7; i++) begin
      do_load(addr_v[i], f3_v[i], 5'd2);
      tests_run++;
      if (read_data_w !== exp_v[i]) begin
        tests_failed++;
        $display("FAIL extract[%0d] addr=%h f3=%b: got %h expected %h", i, addr_v[i], f3_v[i], read_data_w, exp_v[i]);
      end
    end
  endtask

  task automatic test_bypass;
    m2_store(32'h101, 3'b000, 32'h00000055);
    alu_result_m1 = 32'h100;
    step();
    m2_load(32'h100, 3'b010, 5'd1);
    alu_result_m1 = 32'h0;
    step();
    m2_nop();
    tests_run++; if (read_data_w !== 32'hDEAD55EF) begin tests_failed++; $display("FAIL bypass_sb: got %h expected dead55ef", read_data_w); end
    m2_store(32'h102, 3'b001, 32'hFFFF1234);
    alu_result_m1 = 32'h100;
    step();
    m2_load(32'h100, 3'b010, 5'd1);
    alu_result_m1 = 32'h0;
    step();
    m2_nop();
    tests_run++; if (read_data_w !== 32'h123455EF) begin tests_failed++; $display("FAIL bypass_sh: got %h expected 123455ef", read_data_w); end
    do_load(32'h100, 3'b010, 5'd1);
    tests_run++; if (read_data_w !== 32'h123455EF) begin tests_failed++; $display("FAIL bypass_ram: got %h expected 123455ef", read_data_w); end
  endtask

  task automatic test_misaligned;
    do_load(32'h102, 3'b010, 5'd7);
    tests_run++; if (misaligned_w !== 1'b1) begin tests_failed++; $display("FAIL mis_lw_flag: got %b expected 1", misaligned_w); end
    tests_run++; if (reg_write_w !== 1'b0) begin tests_failed++; $display("FAIL mis_lw_reg_write: got %b expected 0", reg_write_w); end
    do_load(32'h101, 3'b001, 5'd7);
    tests_run++; if (misaligned_w !== 1'b1) begin tests_failed++; $display("FAIL mis_lh_flag: got %b expected 1", misaligned_w); end
    do_store(32'h101, 3'b001, 32'h0000AAAA);
    tests_run++; if (misaligned_w !== 1'b1) begin tests_failed++; $display("FAIL mis_sh_flag: got %b expected 1", misaligned_w); end
    do_load(32'h100, 3'b010, 5'd7);
    tests_run++; if (read_data_w !== 32'h123455EF) begin tests_failed++; $display("FAIL mis_sh_nowrite: got %h expected 123455ef", read_data_w); end
    tests_run++; if (misaligned_w !== 1'b0) begin tests_failed++; $display("FAIL aligned_lw_flag: got %b expected 0", misaligned_w); end
    reg_write_m2  = 1'b1;
    result_src_m2 = 2'b00;
    funct3_m2     = 3'b010;
    alu_result_m2 = 32'h103;
    rd_m2         = 5'd8;
    step();
    m2_nop();
    tests_run++; if (misaligned_w !== 1'b0) begin tests_failed++; $display("FAIL alu_op_flag: got %b expected 0", misaligned_w); end
    tests_run++; if (reg_write_w !== 1'b1) begin tests_failed++; $display("FAIL alu_op_reg_write: got %b expected 1", reg_write_w); end
  endtask

  task automatic test_stall;
    do_load(32'h100, 3'b010, 5'd3);
    m2_store(32'h200, 3'b010, 32'hCAFEF00D);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++; if (read_data_w !== 32'h123455EF) begin tests_failed++; $display("FAIL stall_data[%0d]: got %h expected 123455ef", i, read_data_w); end
      tests_run++; if (alu_result_w !== 32'h100) begin tests_failed++; $display("FAIL stall_alu[%0d]: got %h expected 100", i, alu_result_w); end
    end
    stall = 1'b0;
    step();
    m2_nop();
    tests_run++; if (alu_result_w !== 32'h200) begin tests_failed++; $display("FAIL stall_release_alu: got %h expected 200", alu_result_w); end
    tests_run++; if (reg_write_w !== 1'b0) begin tests_failed++; $display("FAIL stall_release_reg_write: got %b expected 0", reg_write_w); end
    do_load(32'h200, 3'b010, 5'd3);
    tests_run++; if (read_data_w !== 32'hCAFEF00D) begin tests_failed++; $display("FAIL stall_store_ram: got %h expected cafef00d", read_data_w); end
    // Read data captured before the stall must survive a changing M1 address.
    alu_result_m1 = 32'h100;
    step();
    m2_load(32'h100, 3'b010, 5'd4);
    alu_result_m1 = 32'h200;
    stall = 1'b1;
    step();
    step();
    stall = 1'b0;
    step();
    m2_nop();
    tests_run++; if (read_data_w !== 32'h123455EF) begin tests_failed++; $display("FAIL stall_rdata_hold: got %h expected 123455ef", read_data_w); end
    tests_run++; if (rd_w !== 5'd4) begin tests_failed++; $display("FAIL stall_rdata_rd: got %0d expected 4", rd_w); end
  endtask

  task automatic test_back_to_back;
    m2_store(32'h300, 3'b010, 32'h11223344);
    alu_result_m1 = 32'h300;
    step();
    m2_load(32'h300, 3'b010, 5'd9);
    alu_result_m1 = 32'h0;
    step();
    m2_nop();
    tests_run++; if (read_data_w !== 32'h11223344) begin tests_failed++; $display("FAIL b2b_sw_lw: got %h expected 11223344", read_data_w); end
    m2_store(32'h304, 3'b010, 32'hAAAAAAAA);
    alu_result_m1 = 32'h0;
    step();
    m2_store(32'h304, 3'b000, 32'h00000077);
    alu_result_m1 = 32'h304;
    step();
    m2_load(32'h304, 3'b010, 5'd9);
    alu_result_m1 = 32'h0;
    step();
    m2_nop();
    tests_run++; if (read_data_w !== 32'hAAAAAA77) begin tests_failed++; $display("FAIL b2b_sw_sb_lw: got %h expected aaaaaa77", read_data_w); end
    do_load(32'h304, 3'b010, 5'd9);
    tests_run++; if (read_data_w !== 32'hAAAAAA77) begin tests_failed++; $display("FAIL b2b_sw_sb_ram: got %h expected aaaaaa77", read_data_w); end
    m2_store(32'h308, 3'b010, 32'h01020304);
    step();
    m2_store(32'h308, 3'b010, 32'h05060708);
    step();
    m2_nop();
    do_load(32'h308, 3'b010, 5'd9);
    tests_run++; if (read_data_w !== 32'h05060708) begin tests_failed++; $display("FAIL b2b_last_wins: got %h expected 05060708", read_data_w); end
  endtask

  task automatic test_reset_mid_store;
    m2_store(32'h104, 3'b010, 32'h0F0F0F0F);
    alu_result_m1 = 32'h104;
    step();
    m2_store(32'h100, 3'b010, 32'hBADBAD00);
    alu_result_m1 = 32'h100;
    #2;
    rst = 1'b1;
    #1;
    tests_run++; if (alu_result_w !== 32'h0) begin tests_failed++; $display("FAIL midrst_alu: got %h expected 0", alu_result_w); end
    tests_run++; if (pc_plus4_w !== 32'h0) begin tests_failed++; $display("FAIL midrst_pc_plus4: got %h expected 0", pc_plus4_w); end
    tests_run++; if (read_data_w !== 32'h0) begin tests_failed++; $display("FAIL midrst_read_data: got %h expected 0", read_data_w); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    stall = 1'b1;
    m2_load(32'h104, 3'b010, 5'd6);
    alu_result_m1 = 32'h0;
    step();
    stall = 1'b0;
    m2_nop();
    tests_run++; if (read_data_w !== 32'h0) begin tests_failed++; $display("FAIL postrst_rdata_clear: got %h expected 0", read_data_w); end
    tests_run++; if (reg_write_w !== 1'b1) begin tests_failed++; $display("FAIL postrst_first_edge: got %b expected 1", reg_write_w); end
    do_load(32'h100, 3'b010, 5'd6);
    tests_run++; if (read_data_w !== 32'h123455EF) begin tests_failed++; $display("FAIL midrst_no_commit: got %h expected 123455ef", read_data_w); end
    do_load(32'h104, 3'b010, 5'd6);
    tests_run++; if (read_data_w !== 32'h0F0F0F0F) begin tests_failed++; $display("FAIL prerst_store_kept: got %h expected 0f0f0f0f", read_data_w); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_load_extract();
    test_bypass();
    test_misaligned();
    test_stall();
    test_back_to_back();
    test_reset_mid_store();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
